// File: rtl/mdr_mem_if.sv
// Memory data register with a request/acknowledge memory port.
// Handles byte/halfword lane formatting for stores and loads, and a wait-cycle timeout.
module mdr_mem_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Ld_Bus,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              Mem_Rd,
  input  logic              Mem_Wr,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [DATA_W-1:0] Mem_Data_In,
  input  logic              MFC,
  output logic [DATA_W-1:0] Out_MDR,
  output logic [DATA_W-1:0] Mem_Data_Out,
  output logic              MOV,
  output logic              Mem_RW,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout_Err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W:0]    cnt_inc;
  logic [1:0]        size_q, size_nxt;
  logic              signed_q, signed_nxt;
  logic [DATA_W-1:0] mdr_nxt, mdo_nxt;
  logic              mov_nxt, rw_nxt, busy_nxt, done_nxt, to_nxt;

  function automatic logic [DATA_W-1:0] store_fmt(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] sz);
    case (sz)
      2'b00:   store_fmt = {(DATA_W / 8){d[7:0]}};
      2'b01:   store_fmt = {(DATA_W / 16){d[15:0]}};
      default: store_fmt = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic sg);
    case (sz)
      2'b00:   load_fmt = {{(DATA_W - 8){sg & d[7]}}, d[7:0]};
      2'b01:   load_fmt = {{(DATA_W - 16){sg & d[15]}}, d[15:0]};
      default: load_fmt = d;
    endcase
  endfunction

  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    size_nxt   = size_q;
    signed_nxt = signed_q;
    mdr_nxt    = Out_MDR;
    mdo_nxt    = Mem_Data_Out;
    mov_nxt    = MOV;
    rw_nxt     = Mem_RW;
    busy_nxt   = Busy;
    done_nxt   = 1'b0;
    to_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_Rd) begin
          state_nxt  = RD_WAIT;
          cnt_nxt    = '0;
          size_nxt   = Size;
          signed_nxt = Signed;
          mov_nxt    = 1'b1;
          rw_nxt     = 1'b1;
          busy_nxt   = 1'b1;
        end else begin
          if (Ld_Bus) mdr_nxt = Bus_In;
          if (Mem_Wr) begin
            state_nxt  = WR_WAIT;
            cnt_nxt    = '0;
            size_nxt   = Size;
            signed_nxt = Signed;
            mdo_nxt    = store_fmt(Ld_Bus ? Bus_In : Out_MDR, Size);
            mov_nxt    = 1'b1;
            rw_nxt     = 1'b0;
            busy_nxt   = 1'b1;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // MFC takes priority over a timeout landing on the same edge
        if (MFC) begin
          if (state == RD_WAIT) mdr_nxt = load_fmt(Mem_Data_In, size_q, signed_q);
          state_nxt = IDLE;
          mov_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if ((TIMEOUT_CYC != 0) && (cnt_inc == TO_VAL)) begin
          state_nxt = IDLE;
          mov_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        mov_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      Out_MDR      <= '0;
      Mem_Data_Out <= '0;
      MOV          <= 1'b0;
      Mem_RW       <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Timeout_Err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      size_q       <= size_nxt;
      signed_q     <= signed_nxt;
      Out_MDR      <= mdr_nxt;
      Mem_Data_Out <= mdo_nxt;
      MOV          <= mov_nxt;
      Mem_RW       <= rw_nxt;
      Busy         <= busy_nxt;
      Done         <= done_nxt;
      Timeout_Err  <= to_nxt;
    end
  end

endmodule
